// File: rtl/mod_seq_checker.sv
// mod_seq_checker
//   Downstream monitor for the 3-bit mod5 -> mod3 -> mod6 sequence counter.
//   One frame is 0-4, 0-2, 0-5 (14 samples). The block hunts for the unique
//   5->0 edge. Once aligned it checks every qualified sample against the
//   expected value and reports phase, pulses, a frame count and error status.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   en         in   sample qualifier for cnt_in
//   cnt_in     in   [2:0] value from the upstream counter
//   err_clr    in   clears err_sticky / err_cnt (honoured regardless of en)
//   locked     out  aligned and checking
//   phase      out  [1:0] phase of next expected sample (0=MOD5,1=MOD3,2=MOD6)
//   phase_end  out  pulse: matched sample equalled the phase limit
//   frame_done out  pulse: matched the final 5 of MOD6
//   frame_cnt  out  [FRAME_W-1:0] completed frames, saturating
//   err        out  pulse: mismatch while locked
//   err_sticky out  set on any err, cleared by err_clr / rst
//   err_cnt    out  [ERR_W-1:0] mismatch count, saturating
module mod_seq_checker #(
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned ERR_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2:0]         cnt_in,
    input  logic               err_clr,
    output logic               locked,
    output logic [1:0]         phase,
    output logic               phase_end,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               err,
    output logic               err_sticky,
    output logic [ERR_W-1:0]   err_cnt
);

    typedef enum logic {HUNT, LOCKED} state_t;
    typedef enum logic [1:0] {MOD5 = 2'd0, MOD3 = 2'd1, MOD6 = 2'd2} phase_t;

    state_t             state_q, state_n;
    phase_t             phase_q, phase_n;
    logic [2:0]         exp_q, exp_n;
    logic [2:0]         prev_q, prev_n;
    logic               prev_vld_q, prev_vld_n;
    logic               pe_q, pe_n;
    logic               fd_q, fd_n;
    logic               err_q, err_n;
    logic               sticky_q, sticky_n;
    logic [FRAME_W-1:0] fcnt_q, fcnt_n;
    logic [ERR_W-1:0]   ecnt_q, ecnt_n;
    logic [2:0]         lim;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            phase_q    <= MOD5;
            exp_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            pe_q       <= 1'b0;
            fd_q       <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            fcnt_q     <= '0;
            ecnt_q     <= '0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            exp_q      <= exp_n;
            prev_q     <= prev_n;
            prev_vld_q <= prev_vld_n;
            pe_q       <= pe_n;
            fd_q       <= fd_n;
            err_q      <= err_n;
            sticky_q   <= sticky_n;
            fcnt_q     <= fcnt_n;
            ecnt_q     <= ecnt_n;
        end
    end

    always_comb begin
        case (phase_q)
            MOD5:    lim = 3'd4;
            MOD3:    lim = 3'd2;
            default: lim = 3'd5;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        phase_n    = phase_q;
        exp_n      = exp_q;
        prev_n     = prev_q;
        prev_vld_n = prev_vld_q;
        pe_n       = 1'b0;
        fd_n       = 1'b0;
        err_n      = 1'b0;
        sticky_n   = sticky_q;
        fcnt_n     = fcnt_q;
        ecnt_n     = ecnt_q;

        // Clear is applied first so a coincident mismatch overrides it
        // and leaves the count at exactly one.
        if (err_clr) begin
            sticky_n = 1'b0;
            ecnt_n   = '0;
        end

        if (en) begin
            prev_n     = cnt_in;
            prev_vld_n = 1'b1;
            case (state_q)
                HUNT: begin
                    if (prev_vld_q && prev_q == 3'd5 && cnt_in == 3'd0) begin
                        state_n = LOCKED;
                        phase_n = MOD5;
                        exp_n   = 3'd1;
                    end
                end
                LOCKED: begin
                    if (cnt_in != exp_q) begin
                        err_n    = 1'b1;
                        sticky_n = 1'b1;
                        if (ecnt_n != '1) ecnt_n = ecnt_n + ERR_W'(1);
                        state_n  = HUNT;
                    end else if (cnt_in == lim) begin
                        pe_n  = 1'b1;
                        exp_n = '0;
                        case (phase_q)
                            MOD5:    phase_n = MOD3;
                            MOD3:    phase_n = MOD6;
                            default: begin
                                phase_n = MOD5;
                                fd_n    = 1'b1;
                                if (fcnt_q != '1) fcnt_n = fcnt_q + FRAME_W'(1);
                            end
                        endcase
                    end else begin
                        exp_n = cnt_in + 3'd1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign locked     = (state_q == LOCKED);
    assign phase      = phase_q;
    assign phase_end  = pe_q;
    assign frame_done = fd_q;
    assign frame_cnt  = fcnt_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_mod_seq_checker.sv
// Bench for mod_seq_checker: a default-width instance and a narrow
// (FRAME_W=2, ERR_W=2) instance share one stimulus stream. A frame-position
// model predicts outputs every cycle; directed checks pin key values.
module tb_mod_seq_checker;

    logic clk, rst, en, err_clr;
    logic [2:0] cnt_in;

    logic       a_locked, a_pe, a_fd, a_err, a_sticky;
    logic [1:0] a_phase;
    logic [7:0] a_fcnt;
    logic [3:0] a_ecnt;
    logic       b_locked, b_pe, b_fd, b_err, b_sticky;
    logic [1:0] b_phase;
    logic [1:0] b_fcnt;
    logic [1:0] b_ecnt;

    mod_seq_checker #(.FRAME_W(8), .ERR_W(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .err_clr(err_clr),
        .locked(a_locked), .phase(a_phase), .phase_end(a_pe), .frame_done(a_fd),
        .frame_cnt(a_fcnt), .err(a_err), .err_sticky(a_sticky), .err_cnt(a_ecnt)
    );

    mod_seq_checker #(.FRAME_W(2), .ERR_W(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .err_clr(err_clr),
        .locked(b_locked), .phase(b_phase), .phase_end(b_pe), .frame_done(b_fd),
        .frame_cnt(b_fcnt), .err(b_err), .err_sticky(b_sticky), .err_cnt(b_ecnt)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    int g[14] = '{0, 1, 2, 3, 4, 0, 1, 2, 0, 1, 2, 3, 4, 5};

    // model state: frame position of next expected sample
    int m_locked, m_pos, m_prev, m_pvld, m_pe, m_fd, m_err, m_sticky;
    int m_frames, m_errs;
    int cyc = 0;

    bit win = 0;
    int pe_seen, fd_seen;
    int fd_cyc[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int ph(input int pos);
        return (pos < 5) ? 0 : (pos < 8) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // behavioural model, evaluated at each rising edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_locked = 0; m_pos = 0; m_prev = 0; m_pvld = 0;
                m_pe = 0; m_fd = 0; m_err = 0; m_sticky = 0;
                m_frames = 0; m_errs = 0;
            end else begin
                m_pe = 0; m_fd = 0; m_err = 0;
                if (err_clr) begin
                    m_sticky = 0;
                    m_errs = 0;
                end
                if (en) begin
                    if (m_locked == 0) begin
                        if (m_pvld == 1 && m_prev == 5 && int'(cnt_in) == 0) begin
                            m_locked = 1;
                            m_pos = 1;
                        end
                    end else if (int'(cnt_in) != g[m_pos]) begin
                        m_err = 1; m_sticky = 1; m_errs++; m_locked = 0;
                    end else begin
                        if (m_pos == 4 || m_pos == 7 || m_pos == 13) m_pe = 1;
                        if (m_pos == 13) begin
                            m_fd = 1;
                            m_frames++;
                        end
                        m_pos = (m_pos + 1) % 14;
                    end
                    m_prev = int'(cnt_in);
                    m_pvld = 1;
                end
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("a.locked",     int'(a_locked), m_locked);
                chk("a.phase",      int'(a_phase),  ph(m_pos));
                chk("a.phase_end",  int'(a_pe),     m_pe);
                chk("a.frame_done", int'(a_fd),     m_fd);
                chk("a.frame_cnt",  int'(a_fcnt),   sat(m_frames, 8));
                chk("a.err",        int'(a_err),    m_err);
                chk("a.err_sticky", int'(a_sticky), m_sticky);
                chk("a.err_cnt",    int'(a_ecnt),   sat(m_errs, 4));
                chk("b.locked",     int'(b_locked), m_locked);
                chk("b.phase",      int'(b_phase),  ph(m_pos));
                chk("b.frame_cnt",  int'(b_fcnt),   sat(m_frames, 2));
                chk("b.err_cnt",    int'(b_ecnt),   sat(m_errs, 2));
                chk("b.err_sticky", int'(b_sticky), m_sticky);
                chk("b.pulses",     int'({b_pe, b_fd, b_err}), (m_pe << 2) | (m_fd << 1) | m_err);
            end
        end
    end

    task automatic smp(input bit e, input int v, input bit clr);
        en = e;
        cnt_in = 3'(v);
        err_clr = clr;
        @(negedge clk);
        if (win) begin
            if (a_pe) pe_seen++;
            if (a_fd) begin
                fd_seen++;
                fd_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic frame(input int from);
        for (int i = from; i < 14; i++) smp(1, g[i], 0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".locked"},     int'(a_locked), 0);
        chk({tag, ".phase"},      int'(a_phase),  0);
        chk({tag, ".pulses"},     int'({a_pe, a_fd, a_err}), 0);
        chk({tag, ".frame_cnt"},  int'(a_fcnt),   0);
        chk({tag, ".err_sticky"}, int'(a_sticky), 0);
        chk({tag, ".err_cnt"},    int'(a_ecnt),   0);
    endtask

    initial begin
        rst = 1; en = 0; cnt_in = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        all_zero("reset");
        rst = 0;

        // 1. lock on the golden stream
        begin
            int s1[15] = '{0, 1, 2, 3, 4, 0, 1, 2, 0, 1, 2, 3, 4, 5, 0};
            for (int i = 0; i < 15; i++) begin
                smp(1, s1[i], 0);
                if (i == 13) chk("t1.unlocked_before_edge", int'(a_locked), 0);
            end
        end
        chk("t1.locked", int'(a_locked), 1);
        chk("t1.no_err", int'(a_sticky), 0);

        // 2. three frames
        pe_seen = 0; fd_seen = 0; win = 1;
        frame(1);
        frame(0);
        frame(0);
        win = 0;
        chk("t2.phase_end_count", pe_seen, 9);
        chk("t2.frame_done_count", fd_seen, 3);
        if (fd_cyc.size() == 3) begin
            chk("t2.fd_spacing0", fd_cyc[1] - fd_cyc[0], 14);
            chk("t2.fd_spacing1", fd_cyc[2] - fd_cyc[1], 14);
        end else begin
            chk("t2.fd_cyc_size", fd_cyc.size(), 3);
        end
        chk("t2.a_frame_cnt", int'(a_fcnt), 3);
        chk("t2.b_frame_cnt", int'(b_fcnt), 3);

        // 3. mismatch in MOD3
        begin
            int s3[8] = '{0, 1, 2, 3, 4, 0, 1, 3};
            for (int i = 0; i < 8; i++) smp(1, s3[i], 0);
        end
        chk("t3.err", int'(a_err), 1);
        chk("t3.locked", int'(a_locked), 0);
        chk("t3.sticky", int'(a_sticky), 1);
        chk("t3.err_cnt", int'(a_ecnt), 1);
        chk("t3.phase_held", int'(a_phase), 1);
        smp(1, 5, 0);
        smp(1, 0, 0);
        chk("t3.relock", int'(a_locked), 1);
        chk("t3.frame_cnt", int'(a_fcnt), 3);

        // 4. enable gap mid-MOD6
        for (int i = 1; i < 11; i++) smp(1, g[i], 0);
        begin
            int junk[7] = '{5, 0, 7, 6, 5, 0, 3};
            for (int i = 0; i < 7; i++) begin
                smp(0, junk[i], 0);
                chk("t4.gap_err", int'(a_err), 0);
                chk("t4.gap_phase", int'(a_phase), 2);
                chk("t4.gap_locked", int'(a_locked), 1);
            end
        end
        smp(1, 3, 0);
        smp(1, 4, 0);
        smp(1, 5, 0);
        chk("t4.frame_done", int'(a_fd), 1);
        chk("t4.frame_cnt", int'(a_fcnt), 4);
        chk("t4.err_cnt", int'(a_ecnt), 1);

        // 5. saturation
        for (int f = 0; f < 5; f++) frame(0);
        chk("t5.a_frame_cnt", int'(a_fcnt), 9);
        chk("t5.b_frame_cnt", int'(b_fcnt), 3);
        smp(0, 0, 1);
        chk("t5.clr_no_en_cnt", int'(a_ecnt), 0);
        chk("t5.clr_no_en_sticky", int'(a_sticky), 0);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                smp(1, 7, 0);
                chk("t5.err7", int'(a_err), 1);
                smp(1, 5, 0);
            end else begin
                smp(1, 5, 0);
                chk("t5.err5", int'(a_err), 1);
            end
            smp(1, 0, 0);
            chk("t5.relock", int'(a_locked), 1);
        end
        chk("t5.a_err_cnt", int'(a_ecnt), 5);
        chk("t5.b_err_cnt", int'(b_ecnt), 3);
        chk("t5.b_frame_cnt_kept", int'(b_fcnt), 3);

        // 6. reset mid-frame (phase MOD6), then coincident clear+error
        for (int i = 1; i < 10; i++) smp(1, g[i], 0);
        chk("t6.pre_phase", int'(a_phase), 2);
        rst = 1;
        smp(1, 5, 0);
        rst = 0;
        all_zero("t6.rst");
        smp(1, 0, 0);
        chk("t6.hunt_after_rst", int'(a_locked), 0);
        smp(1, 5, 0);
        smp(1, 0, 0);
        chk("t6.lock", int'(a_locked), 1);
        for (int k = 0; k < 2; k++) begin
            smp(1, 7, 0);
            smp(1, 5, 0);
            smp(1, 0, 0);
        end
        chk("t6.err_cnt2", int'(a_ecnt), 2);
        smp(1, 7, 1);
        chk("t6.clr_vs_err_sticky", int'(a_sticky), 1);
        chk("t6.clr_vs_err_cnt", int'(a_ecnt), 1);
        chk("t6.clr_vs_err_pulse", int'(a_err), 1);
        smp(0, 0, 0);
        chk("t6.err_pulse_clears", int'(a_err), 0);

        repeat (2) smp(0, 0, 0);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
